// File: rtl/axi_llc_way_arbiter.sv
// Locking round-robin arbiter sharing one data way port between LLC units.
// A routing FIFO of requester indices steers in-order read responses back to their issuer.
package axi_llc_pkg;
  localparam int unsigned DataMacroLatency = 1;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } way_inp_t;

  typedef logic [31:0] way_oup_t;
endpackage

module axi_llc_way_arbiter #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned RouteDepth = axi_llc_pkg::DataMacroLatency + 2,
  parameter type         way_inp_t  = axi_llc_pkg::way_inp_t,
  parameter type         way_oup_t  = axi_llc_pkg::way_oup_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              test_i,
  input  way_inp_t          req_i [NumReq],
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  output way_inp_t          way_inp_o,
  output logic              way_inp_valid_o,
  input  logic              way_inp_ready_i,
  input  way_oup_t          way_out_i,
  input  logic              way_out_valid_i,
  output logic              way_out_ready_o,
  output way_oup_t          rsp_o,
  output logic [NumReq-1:0] rsp_valid_o,
  input  logic [NumReq-1:0] rsp_ready_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (RouteDepth > 1) ? $clog2(RouteDepth) : 1;
  localparam int unsigned CntW = $clog2(RouteDepth + 1);

  typedef logic [IdxW-1:0] idx_t;

  idx_t              rr_q, lock_idx_q, arb_idx, grant, head, cand_idx;
  logic              lock_q, arb_found, handshake, push, pop;
  logic              fifo_full, fifo_empty;
  logic [NumReq-1:0] eligible;
  int unsigned       cand;

  idx_t              route_mem [RouteDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  // Testmode only matters for the clock-gated FIFO flavour; this one is plain flops.
  logic unused_test;
  assign unused_test = test_i;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unit
    assign eligible[gi]    = req_valid_i[gi] & (req_i[gi].we | ~fifo_full);
    assign req_ready_o[gi] = handshake & (grant == idx_t'(gi));
    assign rsp_valid_o[gi] = way_out_valid_i & ~fifo_empty & (head == idx_t'(gi));
  end

  // First eligible unit at or after rr_q, wrapping explicitly for any NumReq.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = idx_t'(cand);
      if (!arb_found && eligible[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign grant           = lock_q ? lock_idx_q : arb_idx;
  assign way_inp_o       = req_i[grant];
  assign way_inp_valid_o = lock_q | (|eligible);
  assign handshake       = way_inp_valid_o & way_inp_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (handshake) begin
      rr_q   <= (grant == idx_t'(NumReq - 1)) ? '0 : idx_t'(grant + idx_t'(1));
      lock_q <= 1'b0;
    end else if (way_inp_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant;
    end
  end

  // Full is judged before any same-cycle pop, so a read never pushes into a full FIFO.
  assign fifo_full  = (count_q == CntW'(RouteDepth));
  assign fifo_empty = (count_q == '0);
  assign push       = handshake & ~way_inp_o.we & ~fifo_full;
  assign head       = route_mem[rd_ptr_q];

  assign rsp_o           = way_out_i;
  assign way_out_ready_o = rsp_ready_i[head] & ~fifo_empty;
  assign pop             = way_out_valid_i & way_out_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) route_mem[wr_ptr_q] <= grant;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(RouteDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(RouteDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_way_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (way_inp_valid_o && !way_inp_ready_i) |=> (way_inp_valid_o && $stable(way_inp_o)));
  a_lock_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_valid_i[lock_idx_q]);
  a_rsp_routed: assert property (@(posedge clk_i) disable iff (!rst_ni)
    way_out_valid_i |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based model of the arbiter.
module tb_axi_llc_way_arbiter;
  import axi_llc_pkg::*;

  localparam int N = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         test = 1'b0;
  way_inp_t     req [N];
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  way_inp_t     way_inp;
  logic         way_inp_valid, way_ready;
  way_oup_t     way_out, rsp;
  logic         out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_llc_way_arbiter #(.NumReq(N), .RouteDepth(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_i(test),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .way_inp_o(way_inp), .way_inp_valid_o(way_inp_valid), .way_inp_ready_i(way_ready),
    .way_out_i(way_out), .way_out_valid_i(out_valid), .way_out_ready_o(out_ready),
    .rsp_o(rsp), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready)
  );

  function automatic way_inp_t mk(bit we);
    way_inp_t p;
    p.we   = we;
    p.addr = 8'($urandom);
    p.data = $urandom;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) req[i] = '0;
    req_valid = '0;
    way_ready = 1'b0;
    out_valid = 1'b0;
    way_out   = '0;
    rsp_ready = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one read per cycle from the listed units with the way always ready.
  task automatic issue_reads(input int u0, input int u1, input int u2, input int cnt, input string tag);
    int us [3];
    us = '{u0, u1, u2};
    way_ready = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      req[us[k]] = mk(1'b0);
      req_valid  = 4'b0001 << us[k];
      #1;
      checks++;
      if (req_ready !== (4'b0001 << us[k])) begin
        errors++; $display("FAIL %s read grant u%0d: got %b want %b", tag, us[k], req_ready, 4'b0001 << us[k]);
      end
      tick();
    end
    req_valid = '0;
    way_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rsp_ready = '1;
    rst_n = 1'b0;
    tick();
    checks++;
    if (way_inp_valid !== 1'b0 || req_ready !== 4'b0) begin
      errors++; $display("FAIL reset req side: valid=%b ready=%b want 0/0000", way_inp_valid, req_ready);
    end
    checks++;
    if (rsp_valid !== 4'b0 || out_ready !== 1'b0) begin
      errors++; $display("FAIL reset rsp side: rsp_valid=%b out_ready=%b want 0000/0", rsp_valid, out_ready);
    end
    rst_n = 1'b1;
    idle();
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    way_oup_t d;
    req[2] = mk(1'b0);
    req_valid = 4'b0100;
    way_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_read ready: got %b want 0100", req_ready);
    end
    checks++;
    if (way_inp_valid !== 1'b1 || way_inp !== req[2]) begin
      errors++; $display("FAIL single_read way_inp: valid=%b got %h want %h", way_inp_valid, way_inp, req[2]);
    end
    tick();
    idle();
    d = $urandom;
    way_out = d; out_valid = 1'b1; rsp_ready = '1;
    #1;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp !== d) begin
      errors++; $display("FAIL single_read rsp: valid=%b data=%h want 0100/%h", rsp_valid, rsp, d);
    end
    checks++;
    if (out_ready !== 1'b1) begin
      errors++; $display("FAIL single_read out_ready: got %b want 1", out_ready);
    end
    tick();
    out_valid = 1'b0;
    #1;
    checks++;
    if (out_ready !== 1'b0) begin
      errors++; $display("FAIL single_read fifo empty after: out_ready=%b want 0", out_ready);
    end
    idle();
    $display("test_single_read done");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) req[i] = mk(1'b1);
    req_valid = '1;
    way_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (req_ready !== (4'b0001 << (k % N)) || way_inp !== req[k % N]) begin
        errors++; $display("FAIL round_robin step %0d: ready=%b want %b", k, req_ready, 4'b0001 << (k % N));
      end
      tick();
    end
    idle();
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure_lock();
    do_reset();
    req[1] = mk(1'b1);
    req[0] = mk(1'b1);
    req_valid = 4'b0010;
    way_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (way_inp_valid !== 1'b1 || way_inp !== req[1] || req_ready !== 4'b0) begin
        errors++; $display("FAIL lock hold cycle %0d: way_inp=%h want %h ready=%b", c, way_inp, req[1], req_ready);
      end
      tick();
      req_valid = 4'b0011;
    end
    way_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || way_inp !== req[1]) begin
      errors++; $display("FAIL lock release: ready=%b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || way_inp !== req[0]) begin
      errors++; $display("FAIL lock next grant: ready=%b want 0001", req_ready);
    end
    tick();
    idle();
    $display("test_backpressure_lock done");
  endtask

  task automatic test_fifo_full();
    int order [3];
    do_reset();
    issue_reads(1, 2, 3, 3, "fifo_full");
    req[0] = mk(1'b0);
    req[3] = mk(1'b1);
    req_valid = 4'b1001;
    way_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000 || way_inp !== req[3]) begin
      errors++; $display("FAIL fifo_full write bypass: ready=%b want 1000", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    way_out = $urandom; out_valid = 1'b1; rsp_ready = '1;
    #1;
    checks++;
    if (way_inp_valid !== 1'b0 || req_ready !== 4'b0) begin
      errors++; $display("FAIL fifo_full read blocked during pop: valid=%b ready=%b want 0/0000", way_inp_valid, req_ready);
    end
    checks++;
    if (rsp_valid !== 4'b0010) begin
      errors++; $display("FAIL fifo_full first rsp: got %b want 0010", rsp_valid);
    end
    tick();
    out_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL fifo_full read after pop: ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    way_ready = 1'b0;
    order = '{2, 3, 0};
    for (int k = 0; k < 3; k++) begin
      way_out = $urandom; out_valid = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== (4'b0001 << order[k])) begin
        errors++; $display("FAIL fifo_full drain %0d: got %b want %b", k, rsp_valid, 4'b0001 << order[k]);
      end
      tick();
    end
    idle();
    $display("test_fifo_full done");
  endtask

  task automatic test_out_of_order();
    way_oup_t d;
    issue_reads(3, 0, 2, 3, "ooo");
    rsp_ready = '1;
    out_valid = 1'b1;
    d = $urandom; way_out = d;
    #1;
    checks++;
    if (rsp_valid !== 4'b1000 || rsp !== d) begin
      errors++; $display("FAIL ooo rsp0: valid=%b data=%h want 1000/%h", rsp_valid, rsp, d);
    end
    tick();
    d = $urandom; way_out = d;
    rsp_ready = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0001 || out_ready !== 1'b0) begin
        errors++; $display("FAIL ooo stall %0d: valid=%b out_ready=%b want 0001/0", c, rsp_valid, out_ready);
      end
      tick();
    end
    rsp_ready = '1;
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || out_ready !== 1'b1 || rsp !== d) begin
      errors++; $display("FAIL ooo rsp1: valid=%b out_ready=%b want 0001/1", rsp_valid, out_ready);
    end
    tick();
    way_out = $urandom;
    #1;
    checks++;
    if (rsp_valid !== 4'b0100) begin
      errors++; $display("FAIL ooo rsp2: got %b want 0100", rsp_valid);
    end
    tick();
    idle();
    $display("test_out_of_order done");
  endtask

  task automatic test_reset_midburst();
    way_oup_t d;
    issue_reads(1, 2, 0, 2, "midburst");
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_ready = '1;
    #1;
    checks++;
    if (rsp_valid !== 4'b0 || out_ready !== 1'b0) begin
      errors++; $display("FAIL midburst fifo flushed: rsp_valid=%b out_ready=%b want 0000/0", rsp_valid, out_ready);
    end
    for (int i = 0; i < N; i++) req[i] = mk(1'b1);
    req_valid = '1;
    way_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midburst rr reset: ready=%b want 0001", req_ready);
    end
    tick();
    idle();
    issue_reads(3, 0, 0, 1, "midburst");
    d = $urandom; way_out = d; out_valid = 1'b1; rsp_ready = '1;
    #1;
    checks++;
    if (rsp_valid !== 4'b1000 || rsp !== d) begin
      errors++; $display("FAIL midburst fresh route: valid=%b want 1000", rsp_valid);
    end
    tick();
    idle();
    $display("test_reset_midburst done");
  endtask

  task automatic test_random();
    int           q [$];
    int           rr, lidx, g;
    bit           lock, ev;
    bit           pend [N];
    way_inp_t     pl [N];
    bit [N-1:0]   elig;
    logic [N-1:0] er, erv;
    logic         eor;
    do_reset();
    rr = 0; lock = 0; lidx = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pl[i] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1;
          pl[i]   = mk($urandom_range(0, 2) == 0);
        end
        req[i]       = pl[i];
        req_valid[i] = pend[i];
      end
      way_ready = ($urandom_range(0, 3) != 0);
      out_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      way_out   = $urandom;
      rsp_ready = 4'($urandom) | 4'($urandom);
      #1;
      for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (pl[i].we || q.size() < D);
      ev = 0; g = 0;
      if (lock) begin
        ev = 1; g = lidx;
      end else begin
        for (int k = 0; k < N; k++)
          if (!ev && elig[(rr + k) % N]) begin ev = 1; g = (rr + k) % N; end
      end
      er  = (ev && way_ready) ? (4'b0001 << g) : 4'b0;
      erv = (q.size() > 0 && out_valid) ? (4'b0001 << q[0]) : 4'b0;
      eor = (q.size() > 0) ? rsp_ready[q[0]] : 1'b0;
      checks++;
      if (way_inp_valid !== ev) begin
        errors++; $display("FAIL random c%0d way_valid: got %b want %b", cyc, way_inp_valid, ev);
      end
      if (ev) begin
        checks++;
        if (way_inp !== pl[g]) begin
          errors++; $display("FAIL random c%0d way_inp: got %h want %h (unit %0d)", cyc, way_inp, pl[g], g);
        end
      end
      checks++;
      if (req_ready !== er) begin
        errors++; $display("FAIL random c%0d req_ready: got %b want %b", cyc, req_ready, er);
      end
      checks++;
      if (rsp_valid !== erv || out_ready !== eor) begin
        errors++; $display("FAIL random c%0d rsp: valid=%b ready=%b want %b/%b", cyc, rsp_valid, out_ready, erv, eor);
      end
      if (erv != 0) begin
        checks++;
        if (rsp !== way_out) begin
          errors++; $display("FAIL random c%0d rsp data: got %h want %h", cyc, rsp, way_out);
        end
      end
      if (out_valid && eor) void'(q.pop_front());
      if (ev && way_ready) begin
        if (!pl[g].we) q.push_back(g);
        pend[g] = 0;
        rr      = (g + 1) % N;
        lock    = 0;
      end else if (ev) begin
        lock = 1;
        lidx = g;
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure_lock();
    test_fifo_full();
    test_out_of_order();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
